lcd_timing: RTL and testbench
=============================

LCD_TIMING -- requirements
Module: lcd_timing

Interface
REQ-001 SHALL have parameter DOTS_PER_LINE, 456, dot ticks per scanline.
REQ-002 SHALL have parameter LINES_PER_FRAME, 154, scanlines per frame, including vblank.
REQ-003 SHALL have parameter VISIBLE_LINES, 144, number of rendered lines.
REQ-004 SHALL have parameter OAM_DOTS, 80, length of mode 2.
REQ-005 SHALL have parameter DRAW_DOTS, 172, length of mode 3.
REQ-006 SHALL have port clk, input, 1, system clock; one clock; all state on posedge clk.
REQ-007 SHALL have port reset, input, 1, reset; asynchronous, active-low.
REQ-008 SHALL have port dot_en, input, 1, dot-tick enable; state advances only when high.
REQ-009 SHALL have port lcd_on, input, 1, LCDC bit 7.
REQ-010 SHALL have port lyc, input, 8, LY compare value (FF45).
REQ-011 SHALL have port stat_sel, input, 4, STAT bits 6..3 as {lyc, mode2, mode1, mode0} interrupt enables.
REQ-012 SHALL have port ly, output, 8, current line (FF44).
REQ-013 SHALL have port mode, output, 2, STAT mode: 0 hblank, 1 vblank, 2 oam, 3 draw.
REQ-014 SHALL have port lyc_match, output, 1, STAT bit 2.
REQ-015 SHALL have port drawline, output, 1, one-clk pulse; the renderer draws the line given by ly.
REQ-016 SHALL have port frame_start, output, 1, one-clk pulse at line 0, dot 0.
REQ-017 SHALL have port vblank_irq, output, 1, one-clk pulse on entry to line VISIBLE_LINES.
REQ-018 SHALL have port stat_irq, output, 1, one-clk pulse on a rising edge of the STAT line.

Function
REQ-019 SHALL keep a dot counter 0..DOTS_PER_LINE-1 that increments on dot_en and wraps to 0, incrementing ly at the wrap.
REQ-020 SHALL wrap ly from LINES_PER_FRAME-1 to 0.
REQ-021 SHALL set mode on lines ly<VISIBLE_LINES as follows: dot 0..OAM_DOTS-1 gives 2; next DRAW_DOTS dots give 3; remainder gives 0.
REQ-022 SHALL hold mode at 1 for all dots of lines ly>=VISIBLE_LINES.
REQ-023 SHALL update mode in the same clk in which the dot or ly counter changes.
REQ-024 SHALL assert drawline for exactly one clk on the 2->3 transition; at that time ly equals the line being drawn.
REQ-025 SHALL never assert drawline during mode 1.
REQ-026 SHALL assert frame_start for one clk when the counter state becomes ly=0, dot=0, including after lcd_on rises.
REQ-027 SHALL assert vblank_irq for one clk when ly becomes VISIBLE_LINES.
REQ-028 SHALL compute lyc_match = (ly == lyc) combinationally from registered ly.
REQ-029 SHALL form the STAT line as (sel[3]&lyc_match)|(sel[2]&mode==2)|(sel[1]&mode==1)|(sel[0]&mode==0).
REQ-030 SHALL pulse stat_irq for one clk only on a 0->1 transition of the STAT line; overlapping sources SHALL NOT retrigger.
REQ-031 SHALL make a stat_sel or lyc write that raises a low STAT line produce a stat_irq pulse.
REQ-032 SHALL, when lcd_on=0, force ly=0, dot=0, mode=0, and all pulses low, and hold there regardless of dot_en.
REQ-033 SHALL, on the first dot_en after lcd_on rises, start at line 0, mode 2.
REQ-034 SHALL, when dot_en is low, freeze all counters and keep all pulses deasserted.

Reset
REQ-035 SHALL, while reset=0, asynchronously clear dot and ly to 0, mode to 0, and drawline, frame_start, vblank_irq, stat_irq and the STAT-line history to 0.
REQ-036 SHALL abandon any frame in progress on mid-frame reset; the first dot_en after release with lcd_on=1 behaves as REQ-033.

Structure
REQ-037 SHALL take the mode encoding enum (LcdMode) and the timing constants from the shared video_types package.
REQ-038 SHALL be a single module with no sub-modules; the STAT edge detector is inline.
REQ-039 SHALL drive the renderer's drawline input directly, with frame_start usable as the renderer's line-reset.

Verification
REQ-040 SHALL cover: lcd_on=1, dot_en=1 continuously -> at clk 80 after start mode 2->3 and drawline high 1 clk with ly=0; at dot 252 mode=0.
REQ-041 SHALL cover: run 144*456 dots -> vblank_irq 1 pulse, ly=144, mode=1, no drawline through ly=153; ly wraps to 0 after 154*456 dots with frame_start pulse.
REQ-042 SHALL cover: lyc=10, stat_sel=4'b1000 -> stat_irq exactly once at ly=10 dot 0; lyc_match high for 456 dots.
REQ-043 SHALL cover: stat_sel=4'b0011 across the hblank->vblank boundary at ly=143->144 -> no second stat_irq (line stays high).
REQ-044 SHALL cover: dot_en toggling 1-of-4 clks -> mode 3 entry after 320 clks; pulses remain 1 clk wide.
REQ-045 SHALL cover: reset asserted and lcd_on dropped mid-line ly=50 -> outputs are 0 immediately; after re-enable, ly=0, mode=2, and frame_start pulses.

Source files
------------

// File: rtl/video_types_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : video_types
//  Description : LCD mode encoding, scan timing constants and helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package video_types;

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'd0,
    MODE_VBLANK = 2'd1,
    MODE_OAM    = 2'd2,
    MODE_DRAW   = 2'd3
  } LcdMode;

  localparam int c_DOTS_PER_LINE   = 456;
  localparam int c_LINES_PER_FRAME = 154;
  localparam int c_VISIBLE_LINES   = 144;
  localparam int c_OAM_DOTS        = 80;
  localparam int c_DRAW_DOTS       = 172;

  function automatic LcdMode mode_for(input int dot, input int line,
                                      input int vis, input int oam,
                                      input int draw);
    if (line >= vis)            return MODE_VBLANK;
    else if (dot < oam)         return MODE_OAM;
    else if (dot < oam + draw)  return MODE_DRAW;
    else                        return MODE_HBLANK;
  endfunction

  // Enables are STAT bits 6..3: {lyc, mode2, mode1, mode0}.
  function automatic logic stat_line(input logic match, input LcdMode m,
                                     input logic [3:0] sel);
    return (sel[3] & match)
         | (sel[2] & (m == MODE_OAM))
         | (sel[1] & (m == MODE_VBLANK))
         | (sel[0] & (m == MODE_HBLANK));
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_timing.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_timing
//  Description : LCD dot/line scan counters, STAT mode, LYC compare and
//                frame/line/vblank/STAT interrupt pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_timing
  import video_types::*;
#(
  parameter int DOTS_PER_LINE   = c_DOTS_PER_LINE,
  parameter int LINES_PER_FRAME = c_LINES_PER_FRAME,
  parameter int VISIBLE_LINES   = c_VISIBLE_LINES,
  parameter int OAM_DOTS        = c_OAM_DOTS,
  parameter int DRAW_DOTS       = c_DRAW_DOTS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dot_en,
  input  logic       lcd_on,
  input  logic [7:0] lyc,
  input  logic [3:0] stat_sel,
  output logic [7:0] ly,
  output logic [1:0] mode,
  output logic       lyc_match,
  output logic       drawline,
  output logic       frame_start,
  output logic       vblank_irq,
  output logic       stat_irq
);

  localparam int c_DOT_W = (DOTS_PER_LINE > 1) ? $clog2(DOTS_PER_LINE) : 1;

  logic [c_DOT_W-1:0] r_dot, w_dot_nxt;
  logic [7:0]         r_ly, w_ly_nxt;
  LcdMode             r_mode, w_mode_nxt;
  logic               r_active, w_active_nxt;
  logic               r_stat_line, w_stat_nxt;
  logic               r_drawline, w_drawline_nxt;
  logic               r_frame_start, w_frame_start_nxt;
  logic               r_vblank_irq, w_vblank_irq_nxt;
  logic               r_stat_irq, w_stat_irq_nxt;
  logic               w_dot_wrap;
  logic               w_last_line;

  assign w_dot_wrap  = (r_dot == c_DOT_W'(DOTS_PER_LINE - 1));
  assign w_last_line = (r_ly == 8'(LINES_PER_FRAME - 1));

  // r_active distinguishes "held off" from "running at line 0, dot 0", so the
  // first dot after enable lands on line 0 / mode 2 with a frame_start.
  always_comb begin
    w_active_nxt      = r_active;
    w_dot_nxt         = r_dot;
    w_ly_nxt          = r_ly;
    w_mode_nxt        = r_mode;
    w_stat_nxt        = r_stat_line;
    w_drawline_nxt    = 1'b0;
    w_frame_start_nxt = 1'b0;
    w_vblank_irq_nxt  = 1'b0;
    w_stat_irq_nxt    = 1'b0;
    if (!lcd_on) begin
      w_active_nxt = 1'b0;
      w_dot_nxt    = '0;
      w_ly_nxt     = '0;
      w_mode_nxt   = MODE_HBLANK;
      w_stat_nxt   = 1'b0;
    end else if (dot_en) begin
      if (!r_active) begin
        w_active_nxt      = 1'b1;
        w_dot_nxt         = '0;
        w_ly_nxt          = '0;
        w_frame_start_nxt = 1'b1;
      end else if (w_dot_wrap) begin
        w_dot_nxt         = '0;
        w_ly_nxt          = w_last_line ? 8'd0 : r_ly + 8'd1;
        w_frame_start_nxt = w_last_line;
        w_vblank_irq_nxt  = (w_ly_nxt == 8'(VISIBLE_LINES));
      end else begin
        w_dot_nxt = r_dot + c_DOT_W'(1);
      end
      w_mode_nxt     = mode_for(32'(w_dot_nxt), 32'(w_ly_nxt), VISIBLE_LINES,
                                OAM_DOTS, DRAW_DOTS);
      w_drawline_nxt = (r_mode == MODE_OAM) && (w_mode_nxt == MODE_DRAW);
      // Edge history only advances on dot ticks, so a register write while
      // dot_en is low is seen on the next tick rather than lost.
      w_stat_nxt     = stat_line(w_ly_nxt == lyc, w_mode_nxt, stat_sel);
      w_stat_irq_nxt = w_stat_nxt & ~r_stat_line;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active      <= 1'b0;
      r_dot         <= '0;
      r_ly          <= '0;
      r_mode        <= MODE_HBLANK;
      r_stat_line   <= 1'b0;
      r_drawline    <= 1'b0;
      r_frame_start <= 1'b0;
      r_vblank_irq  <= 1'b0;
      r_stat_irq    <= 1'b0;
    end else begin
      r_active      <= w_active_nxt;
      r_dot         <= w_dot_nxt;
      r_ly          <= w_ly_nxt;
      r_mode        <= w_mode_nxt;
      r_stat_line   <= w_stat_nxt;
      r_drawline    <= w_drawline_nxt;
      r_frame_start <= w_frame_start_nxt;
      r_vblank_irq  <= w_vblank_irq_nxt;
      r_stat_irq    <= w_stat_irq_nxt;
    end
  end

  assign ly          = r_ly;
  assign mode        = r_mode;
  assign lyc_match   = (r_ly == lyc);
  assign drawline    = r_drawline;
  assign frame_start = r_frame_start;
  assign vblank_irq  = r_vblank_irq;
  assign stat_irq    = r_stat_irq;

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_timing
//  Description : Directed checks of lcd_timing scan timing and interrupts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_timing;

  logic       clk = 1'b0;
  logic       reset;
  logic       dot_en;
  logic       lcd_on;
  logic [7:0] lyc;
  logic [3:0] stat_sel;
  logic [7:0] ly;
  logic [1:0] mode;
  logic       lyc_match, drawline, frame_start, vblank_irq, stat_irq;

  int checks = 0;
  int errors = 0;
  int t      = -1;
  int n_dl   = 0;
  int n_irq  = 0;

  typedef struct {
    int         t;
    logic [7:0] lyc;
    logic [3:0] sel;
    int         ly;
    int         mode;
    int         dl, fs, vb, irq, lm;
    int         n_dl, n_irq;
  } vec_t;

  vec_t vecs[18];

  lcd_timing dut (
    .clk        (clk),
    .reset      (reset),
    .dot_en     (dot_en),
    .lcd_on     (lcd_on),
    .lyc        (lyc),
    .stat_sel   (stat_sel),
    .ly         (ly),
    .mode       (mode),
    .lyc_match  (lyc_match),
    .drawline   (drawline),
    .frame_start(frame_start),
    .vblank_irq (vblank_irq),
    .stat_irq   (stat_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; outputs are sampled 1 ns after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
    t++;
    if (drawline) n_dl++;
    if (stat_irq) n_irq++;
  endtask

  task automatic check_outs(input string tag, input int e_ly, input int e_mode,
                            input int e_dl, input int e_fs, input int e_vb,
                            input int e_irq);
    check({tag, ".ly"},    int'(ly), e_ly);
    check({tag, ".mode"},  int'(mode), e_mode);
    check({tag, ".dl"},    int'(drawline), e_dl);
    check({tag, ".fs"},    int'(frame_start), e_fs);
    check({tag, ".vb"},    int'(vblank_irq), e_vb);
    check({tag, ".irq"},   int'(stat_irq), e_irq);
  endtask

  initial begin
    int found;
    int bad;

    // t counts dot ticks since the enabling tick (t=0 is line 0, dot 0).
    //          t      lyc    sel      ly  md dl fs vb ir lm ndl nirq
    vecs[0]  = '{0,     8'd10, 4'b1000, 0,  2, 0, 1, 0, 0, 0, 0,  0};
    vecs[1]  = '{79,    8'd10, 4'b1000, 0,  2, 0, 0, 0, 0, 0, 0,  0};
    vecs[2]  = '{80,    8'd10, 4'b1000, 0,  3, 1, 0, 0, 0, 0, 1,  0};
    vecs[3]  = '{81,    8'd10, 4'b1000, 0,  3, 0, 0, 0, 0, 0, 0,  0};
    vecs[4]  = '{251,   8'd10, 4'b1000, 0,  3, 0, 0, 0, 0, 0, 0,  0};
    vecs[5]  = '{252,   8'd10, 4'b1000, 0,  0, 0, 0, 0, 0, 0, 0,  0};
    vecs[6]  = '{4560,  8'd10, 4'b1000, 10, 2, 0, 0, 0, 1, 1, 9,  1};
    vecs[7]  = '{4561,  8'd10, 4'b1000, 10, 2, 0, 0, 0, 0, 1, 0,  0};
    vecs[8]  = '{5015,  8'd10, 4'b1000, 10, 0, 0, 0, 0, 0, 1, 1,  0};
    vecs[9]  = '{5016,  8'd10, 4'b1000, 11, 2, 0, 0, 0, 0, 0, 0,  0};
    vecs[10] = '{65507, 8'd10, 4'b1000, 143,0, 0, 0, 0, 0, 0, 133,0};
    vecs[11] = '{65508, 8'd10, 4'b0011, 143,0, 0, 0, 0, 1, 0, 0,  1};
    vecs[12] = '{65509, 8'd10, 4'b0011, 143,0, 0, 0, 0, 0, 0, 0,  0};
    vecs[13] = '{65664, 8'd10, 4'b0011, 144,1, 0, 0, 1, 0, 0, 0,  0};
    vecs[14] = '{65665, 8'd10, 4'b0011, 144,1, 0, 0, 0, 0, 0, 0,  0};
    vecs[15] = '{70223, 8'd10, 4'b0011, 153,1, 0, 0, 0, 0, 0, 0,  0};
    vecs[16] = '{70224, 8'd10, 4'b0011, 0,  2, 0, 1, 0, 0, 0, 0,  0};
    vecs[17] = '{93124, 8'd10, 4'b0011, 50, 3, 0, 0, 0, 0, 0, 51, 50};

    reset = 1'b0; lcd_on = 1'b0; dot_en = 1'b0; lyc = 8'd0; stat_sel = 4'd0;
    repeat (3) step();
    check_outs("rst", 0, 0, 0, 0, 0, 0);
    check("rst.lm", int'(lyc_match), 1);
    lcd_on = 1'b1; dot_en = 1'b1;
    step();
    check_outs("rst_held", 0, 0, 0, 0, 0, 0);

    dot_en = 1'b0; reset = 1'b1;
    step();
    check_outs("idle", 0, 0, 0, 0, 0, 0);

    // Dot ticks on one clock in four: draw entry 320 clocks after start.
    found = -1; bad = 0;
    for (int c = 0; c < 1000 && found < 0; c++) begin
      dot_en = (c % 4 == 0);
      step();
      if (c == 0) check_outs("slow.start", 0, 2, 0, 1, 0, 0);
      if (c == 1) check("slow.fs_width", int'(frame_start), 0);
      if ((c % 4 != 0) && (drawline || frame_start || vblank_irq || stat_irq)) bad++;
      if (mode == 2'd3) begin
        found = c;
        check("slow.dl", int'(drawline), 1);
      end
    end
    check("slow.draw_clk", found, 320);
    dot_en = 1'b0;
    step();
    check("slow.dl_width", int'(drawline), 0);
    check("slow.mode_hold", int'(mode), 3);
    check("slow.idle_pulses", bad, 0);

    lcd_on = 1'b0; dot_en = 1'b1;
    step();
    check_outs("off", 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    check_outs("off_hold", 0, 0, 0, 0, 0, 0);

    // Continuous run over a full frame and into the next one.
    lcd_on = 1'b1; dot_en = 1'b1; t = -1;
    for (int i = 0; i < 18; i++) begin
      n_dl = 0; n_irq = 0;
      while (t < vecs[i].t) begin
        lyc = vecs[i].lyc; stat_sel = vecs[i].sel;
        step();
      end
      check_outs($sformatf("v%0d", i), vecs[i].ly, vecs[i].mode, vecs[i].dl,
                 vecs[i].fs, vecs[i].vb, vecs[i].irq);
      check($sformatf("v%0d.lm", i), int'(lyc_match), vecs[i].lm);
      check($sformatf("v%0d.n_dl", i), n_dl, vecs[i].n_dl);
      check($sformatf("v%0d.n_irq", i), n_irq, vecs[i].n_irq);
    end

    // Mid-line reset with LCD dropped: outputs clear without a clock edge.
    reset = 1'b0; lcd_on = 1'b0;
    #1;
    check_outs("mid_rst", 0, 0, 0, 0, 0, 0);
    repeat (2) step();
    reset = 1'b1; lcd_on = 1'b1; dot_en = 1'b1; lyc = 8'd5; stat_sel = 4'b1000;
    step();
    check_outs("restart", 0, 2, 0, 1, 0, 0);
    step();
    check_outs("restart+1", 0, 2, 0, 0, 0, 0);

    // An LYC write that raises the STAT line must interrupt once.
    lyc = 8'd0;
    #1;
    check("lyc_wr.lm", int'(lyc_match), 1);
    step();
    check("lyc_wr.irq", int'(stat_irq), 1);
    step();
    check("lyc_wr.irq_once", int'(stat_irq), 0);

    dot_en = 1'b0;
    repeat (3) step();
    check_outs("freeze", 0, 2, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
